// File: rtl/comparator_search.sv
// Successive-approximation searcher driving a magnitude comparator's x operand.
// Define CMP_SEARCH_CHECK_EN to treat non-one-hot comparator flags as an error.
module comparator_search #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] guess,
  input  logic         eq,
  input  logic         le,
  input  logic         gt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [4:0]   steps,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    ERR
  } state_t;

  state_t state, state_n;

  logic [W:0]   lo, hi, lo_n, hi_n, mid, g_ext;
  logic [W-1:0] guess_n, result_n;
  logic [4:0]   steps_n;
  logic         done_n, err_n;
  logic         hit, go_up, bad_flags, crossed;

  assign g_ext = {1'b0, guess};
  assign busy  = (state == PROBE);

`ifdef CMP_SEARCH_CHECK_EN
  assign hit       = eq & ~le & ~gt;
  assign go_up     = le & ~eq & ~gt;
  assign bad_flags = ~(hit | go_up | (gt & ~eq & ~le));
`else
  // Priority eq > gt > le; an all-zero sample falls through to le.
  logic unused_le;
  assign unused_le = le;
  assign hit       = eq;
  assign go_up     = ~eq & ~gt;
  assign bad_flags = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    guess_n  = guess;
    result_n = result;
    steps_n  = steps;
    done_n   = 1'b0;
    err_n    = err;
    crossed  = 1'b0;
    mid      = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          lo_n    = '0;
          hi_n    = {1'b0, {W{1'b1}}};
          guess_n = hi_n[W:1];
          steps_n = '0;
          err_n   = 1'b0;
          state_n = PROBE;
        end
      end
      PROBE: begin
        steps_n = steps + 5'd1;
        if (bad_flags) begin
          state_n = ERR;
          err_n   = 1'b1;
          done_n  = 1'b1;
        end else if (hit) begin
          result_n = guess;
          done_n   = 1'b1;
          state_n  = IDLE;
        end else begin
          // Crossing is tested before the +/-1 so guess=0 never underflows.
          if (go_up) begin
            lo_n    = g_ext + 1'b1;
            crossed = (g_ext >= hi);
          end else begin
            hi_n    = g_ext - 1'b1;
            crossed = (g_ext <= lo);
          end
          mid     = lo_n + hi_n;
          guess_n = mid[W:1];
          if (crossed) begin
            guess_n = guess;
            state_n = ERR;
            err_n   = 1'b1;
            done_n  = 1'b1;
          end
        end
      end
      ERR: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      result <= '0;
      steps  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      guess  <= guess_n;
      result <= result_n;
      steps  <= steps_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_comparator_search.sv
// Directed bench for comparator_search at W=4 and W=2.
// Inputs change and outputs are sampled on the falling edge.
module tb_comparator_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, start2;
  logic [3:0] guess4, result4, hid4;
  logic [1:0] guess2, result2, hid2;
  logic [4:0] steps4, steps2;
  logic       eq4, le4, gt4, busy4, done4, err4;
  logic       eq2, le2, gt2, busy2, done2, err2;
  logic       all_le4, force4;

  int checks = 0;
  int errors = 0;
  int last4  = 0;

  comparator_search #(.W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .guess(guess4),
    .eq(eq4), .le(le4), .gt(gt4), .busy(busy4), .done(done4),
    .result(result4), .steps(steps4), .err(err4)
  );

  comparator_search #(.W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .guess(guess2),
    .eq(eq2), .le(le2), .gt(gt2), .busy(busy2), .done(done2),
    .result(result2), .steps(steps2), .err(err2)
  );

  always_comb begin
    if (all_le4)
      {eq4, le4, gt4} = 3'b010;
    else if (force4)
      {eq4, le4, gt4} = 3'b011;
    else begin
      eq4 = (guess4 == hid4);
      le4 = (guess4 < hid4);
      gt4 = (guess4 > hid4);
    end
  end

  assign eq2 = (guess2 == hid2);
  assign le2 = (guess2 < hid2);
  assign gt2 = (guess2 > hid2);

  typedef struct {
    int              hidden;
    int              nsteps;
    logic [4:0][3:0] probes;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int h, int n, int a, int b, int c, int d, int e);
    vec_t v;
    v.hidden    = h;
    v.nsteps    = n;
    v.probes[0] = 4'(a);
    v.probes[1] = 4'(b);
    v.probes[2] = 4'(c);
    v.probes[3] = 4'(d);
    v.probes[4] = 4'(e);
    return v;
  endfunction

  // Called on a falling edge; that cycle is cycle 0.
  task automatic run4(vec_t v);
    hid4   = 4'(v.hidden);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 1; c <= v.nsteps; c++) begin
      chk($sformatf("busy h=%0d c=%0d", v.hidden, c), busy4, 1);
      chk($sformatf("early_done h=%0d c=%0d", v.hidden, c), done4, 0);
      chk($sformatf("probe h=%0d c=%0d", v.hidden, c), guess4, v.probes[c-1]);
      @(negedge clk);
    end
    chk($sformatf("done h=%0d", v.hidden), done4, 1);
    chk($sformatf("busy_at_done h=%0d", v.hidden), busy4, 0);
    chk($sformatf("result h=%0d", v.hidden), result4, v.hidden);
    chk($sformatf("steps h=%0d", v.hidden), steps4, v.nsteps);
    chk($sformatf("err h=%0d", v.hidden), err4, 0);
    last4 = v.hidden;
    @(negedge clk);
    chk($sformatf("done_pulse h=%0d", v.hidden), done4, 0);
  endtask

  initial begin
    int exp2[4];
    int idx, cyc;
    logic restarted;

    tbl[0] = mk(7, 1, 7, 0, 0, 0, 0);
    tbl[1] = mk(0, 4, 7, 3, 1, 0, 0);
    tbl[2] = mk(15, 5, 7, 11, 13, 14, 15);
    tbl[3] = mk(3, 2, 7, 3, 0, 0, 0);
    tbl[4] = mk(11, 2, 7, 11, 0, 0, 0);
    tbl[5] = mk(1, 3, 7, 3, 1, 0, 0);
    tbl[6] = mk(8, 4, 7, 11, 9, 8, 0);
    tbl[7] = mk(12, 4, 7, 11, 13, 12, 0);
    tbl[8] = mk(5, 3, 7, 3, 5, 0, 0);
    exp2 = '{2, 1, 2, 3};

    rst_n   = 1'b0;
    start4  = 1'b0;
    start2  = 1'b0;
    hid4    = '0;
    hid2    = '0;
    all_le4 = 1'b0;
    force4  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst guess", guess4, 0);
    chk("rst busy", busy4, 0);
    chk("rst done", done4, 0);
    chk("rst result", result4, 0);
    chk("rst steps", steps4, 0);
    chk("rst err", err4, 0);
    chk("rst busy w2", busy2, 0);
    chk("rst result w2", result2, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) run4(tbl[i]);

    // W=2 back-to-back sweep, restarting on each done cycle.
    hid2      = 2'd0;
    start2    = 1'b1;
    idx       = 0;
    cyc       = 0;
    restarted = 1'b0;
    @(negedge clk);
    while (idx < 4 && cyc < 40) begin
      start2 = 1'b0;
      cyc++;
      if (restarted) chk($sformatf("w2 no gap %0d", idx), busy2, 1);
      restarted = 1'b0;
      if (done2) begin
        chk($sformatf("w2 result %0d", idx), result2, idx);
        chk($sformatf("w2 steps %0d", idx), steps2, exp2[idx]);
        chk($sformatf("w2 steps<=3 %0d", idx), int'(steps2 <= 5'd3), 1);
        chk($sformatf("w2 err %0d", idx), err2, 0);
        idx++;
        if (idx < 4) begin
          hid2      = 2'(idx);
          start2    = 1'b1;
          restarted = 1'b1;
        end
      end
      @(negedge clk);
    end
    chk("w2 sweep complete", idx, 4);

    // Inconsistent le&gt on the second probe, hidden=9.
    hid4   = 4'd9;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("bad probe1", guess4, 7);
    @(negedge clk);
    chk("bad probe2", guess4, 11);
    force4 = 1'b1;
    @(negedge clk);
    force4 = 1'b0;
`ifdef CMP_SEARCH_CHECK_EN
    chk("bad done", done4, 1);
    chk("bad err", err4, 1);
    chk("bad result kept", result4, last4);
    chk("bad busy", busy4, 0);
    @(negedge clk);
    chk("bad err sticky", err4, 1);
    chk("bad back idle", busy4, 0);
`else
    chk("bad as gt probe3", guess4, 9);
    chk("bad busy", busy4, 1);
    @(negedge clk);
    chk("bad done", done4, 1);
    chk("bad result", result4, 9);
    chk("bad steps", steps4, 3);
    chk("bad err", err4, 0);
    last4 = 9;
`endif
    @(negedge clk);

    // Comparator always answers le: bounds cross after probe 15.
    all_le4 = 1'b1;
    start4  = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("cross probe5", guess4, 15);
    chk("cross busy", busy4, 1);
    @(negedge clk);
    chk("cross done", done4, 1);
    chk("cross err", err4, 1);
    chk("cross steps", steps4, 5);
    chk("cross result kept", result4, last4);
    start4 = 1'b1;
    @(negedge clk);
    start4  = 1'b0;
    all_le4 = 1'b0;
    chk("start in ERR ignored", busy4, 0);
    chk("err sticky idle", err4, 1);
    chk("cross done pulse", done4, 0);

    // Reset in cycle 3 of a hidden=15 search.
    hid4   = 4'd15;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst guess", guess4, 0);
    chk("mid rst busy", busy4, 0);
    chk("mid rst done", done4, 0);
    chk("mid rst result", result4, 0);
    chk("mid rst steps", steps4, 0);
    chk("mid rst err", err4, 0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post rst no done", done4, 0);
      chk("post rst idle", busy4, 0);
    end
    run4(tbl[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
